// File: rtl/lnseq_pkg.sv
// Shared types and width helpers for the LogicNets sequential neuron scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, default layer geometry, index-width helpers.
package lnseq_pkg;

  localparam int DEF_IN_BITS   = 64;
  localparam int DEF_FAN_IN    = 8;
  localparam int DEF_N_NEURONS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } lnseq_state_e;

  // Width of an index selecting one bit of the input activation vector.
  function automatic int idx_width(input int in_bits);
    return (in_bits > 1) ? $clog2(in_bits) : 1;
  endfunction

  // Width of a neuron id; never narrower than one bit.
  function automatic int nid_width(input int n_neurons);
    return (n_neurons > 1) ? $clog2(n_neurons) : 1;
  endfunction

endpackage

// File: rtl/lnseq_tt_bank.sv
// Truth-table bank: N_NEURONS tables of 2^FAN_IN one-bit entries.
// Latency: lookup is combinational; optional readback is one registered cycle.
// Backpressure: none, writes and reads are accepted every cycle.
//
// Ports: clk_i; we_i/wr_neuron_i/wr_addr_i/wr_bit_i synchronous write;
//        lk_neuron_i/lk_addr_i -> lk_bit_o asynchronous lookup;
//        with LNSEQ_CFG_READBACK_EN: rst_i, rb_neuron_i/rb_addr_i -> rb_bit_o.
module lnseq_tt_bank import lnseq_pkg::*; #(
  parameter int FAN_IN    = DEF_FAN_IN,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int NID_W     = nid_width(DEF_N_NEURONS)
) (
  input  logic              clk_i,
`ifdef LNSEQ_CFG_READBACK_EN
  input  logic              rst_i,
  input  logic [NID_W-1:0]  rb_neuron_i,
  input  logic [FAN_IN-1:0] rb_addr_i,
  output logic              rb_bit_o,
`endif
  input  logic              we_i,
  input  logic [NID_W-1:0]  wr_neuron_i,
  input  logic [FAN_IN-1:0] wr_addr_i,
  input  logic              wr_bit_i,
  input  logic [NID_W-1:0]  lk_neuron_i,
  input  logic [FAN_IN-1:0] lk_addr_i,
  output logic              lk_bit_o
);

  localparam int DEPTH = 1 << FAN_IN;

  // Table contents are deliberately not reset: they survive a layer reset.
  logic [DEPTH-1:0] tt_q [N_NEURONS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tt_q[wr_neuron_i][wr_addr_i] <= wr_bit_i;
    end
  end

  assign lk_bit_o = tt_q[lk_neuron_i][lk_addr_i];

`ifdef LNSEQ_CFG_READBACK_EN
  logic rb_bit_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rb_bit_q <= 1'b0;
    end else begin
      rb_bit_q <= tt_q[rb_neuron_i][rb_addr_i];
    end
  end

  assign rb_bit_o = rb_bit_q;
`endif

endmodule

// File: rtl/lnseq_neuron_scheduler.sv
// Time-multiplexed LogicNets layer: N_NEURONS LUT neurons share one table bank and lookup path.
// Latency: frame accepted in cycle 0 -> out_valid_o in cycle N_NEURONS+2; one frame per N_NEURONS+3 cycles.
// Backpressure: in_ready_o only in IDLE; result held in EMIT until out_ready_i.
//
// Ports: clk_i, rst_i (sync, active high);
//        tt_we_i/tt_neuron_i/tt_addr_i/tt_bit_i   truth-table bit write (IDLE only);
//        cn_we_i/cn_neuron_i/cn_slot_i/cn_idx_i   connectivity write (IDLE only);
//        cfg_drop_o  sticky flag: a config write arrived outside IDLE;
//        in_valid_i/in_ready_o/in_data_i          input frame handshake;
//        out_valid_o/out_ready_i/out_data_o       layer output handshake, bit n = neuron n;
//        busy_o      state is not IDLE.
// Optional macro LNSEQ_CFG_READBACK_EN adds rb_neuron_i/rb_addr_i -> rb_bit_o (registered readback).
module lnseq_neuron_scheduler import lnseq_pkg::*; #(
  parameter int IN_BITS   = DEF_IN_BITS,
  parameter int FAN_IN    = DEF_FAN_IN,
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int IDX_W     = idx_width(IN_BITS),
  parameter int NID_W     = nid_width(N_NEURONS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       tt_we_i,
  input  logic [NID_W-1:0]           tt_neuron_i,
  input  logic [FAN_IN-1:0]          tt_addr_i,
  input  logic                       tt_bit_i,
  input  logic                       cn_we_i,
  input  logic [NID_W-1:0]           cn_neuron_i,
  input  logic [$clog2(FAN_IN)-1:0]  cn_slot_i,
  input  logic [IDX_W-1:0]           cn_idx_i,
  output logic                       cfg_drop_o,
`ifdef LNSEQ_CFG_READBACK_EN
  input  logic [NID_W-1:0]           rb_neuron_i,
  input  logic [FAN_IN-1:0]          rb_addr_i,
  output logic                       rb_bit_o,
`endif
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IN_BITS-1:0]         in_data_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [N_NEURONS-1:0]       out_data_o,
  output logic                       busy_o
);

  localparam logic [NID_W-1:0] LAST_NID = NID_W'(N_NEURONS - 1);

  lnseq_state_e state_q, state_d;
  logic [NID_W-1:0]     n_q, n_d;
  logic [IN_BITS-1:0]   in_reg_q, in_reg_d;
  logic [N_NEURONS-1:0] out_data_q, out_data_d;
  logic                 cfg_drop_q, cfg_drop_d;

  // Stage-1 -> stage-2 pipeline register: table address and owning neuron.
  logic                 s1_vld_q, s1_vld_d;
  logic [NID_W-1:0]     s1_nid_q, s1_nid_d;
  logic [FAN_IN-1:0]    s1_addr_q, s1_addr_d;

  logic [IDX_W-1:0]     conn_q [N_NEURONS][FAN_IN];
  logic [FAN_IN-1:0]    gather_addr;
  logic                 tt_wr_en;
  logic                 cn_wr_en;
  logic                 lk_bit;

  // Address gather for the neuron currently in stage 1; slot 0 is the LSB.
  always_comb begin
    gather_addr = '0;
    for (int s = 0; s < FAN_IN; s++) begin
      gather_addr[s] = in_reg_q[conn_q[n_q][s]];
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    in_reg_d   = in_reg_q;
    out_data_d = out_data_q;
    cfg_drop_d = cfg_drop_q;
    s1_vld_d   = 1'b0;
    s1_nid_d   = s1_nid_q;
    s1_addr_d  = s1_addr_q;
    tt_wr_en   = 1'b0;
    cn_wr_en   = 1'b0;

    // Stage 2: commit the looked-up bit. Only live in RUN/DRAIN, so it never
    // collides with the clear-on-accept below.
    if (s1_vld_q) begin
      out_data_d[s1_nid_q] = lk_bit;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          in_reg_d   = in_data_i;
          n_d        = '0;
          out_data_d = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        s1_vld_d  = 1'b1;
        s1_nid_d  = n_q;
        s1_addr_d = gather_addr;
        n_d       = n_q + NID_W'(1);
        if (n_q == LAST_NID) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Config is only safe to change while no frame is in flight; a write in
    // the accept cycle lands before the first gather, so that frame sees it.
    if (state_q == IDLE) begin
      tt_wr_en = tt_we_i;
      cn_wr_en = cn_we_i;
    end else if (tt_we_i || cn_we_i) begin
      cfg_drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      n_q        <= '0;
      out_data_q <= '0;
      cfg_drop_q <= 1'b0;
      s1_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      out_data_q <= out_data_d;
      cfg_drop_q <= cfg_drop_d;
      s1_vld_q   <= s1_vld_d;
    end
  end

  // Datapath registers need no reset: they are qualified by state/s1_vld_q.
  always_ff @(posedge clk_i) begin
    in_reg_q  <= in_reg_d;
    s1_nid_q  <= s1_nid_d;
    s1_addr_q <= s1_addr_d;
  end

  // Connectivity survives reset, like the truth tables.
  always_ff @(posedge clk_i) begin
    if (cn_wr_en) begin
      conn_q[cn_neuron_i][cn_slot_i] <= cn_idx_i;
    end
  end

  lnseq_tt_bank #(
    .FAN_IN    (FAN_IN),
    .N_NEURONS (N_NEURONS),
    .NID_W     (NID_W)
  ) u_tt_bank (
    .clk_i       (clk_i),
`ifdef LNSEQ_CFG_READBACK_EN
    .rst_i       (rst_i),
    .rb_neuron_i (rb_neuron_i),
    .rb_addr_i   (rb_addr_i),
    .rb_bit_o    (rb_bit_o),
`endif
    .we_i        (tt_wr_en),
    .wr_neuron_i (tt_neuron_i),
    .wr_addr_i   (tt_addr_i),
    .wr_bit_i    (tt_bit_i),
    .lk_neuron_i (s1_nid_q),
    .lk_addr_i   (s1_addr_q),
    .lk_bit_o    (lk_bit)
  );

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == EMIT);
  assign out_data_o  = out_data_q;
  assign cfg_drop_o  = cfg_drop_q;
  assign busy_o      = (state_q != IDLE);

endmodule
